// File: rtl/rr_onecold_arbiter.sv
// Round-robin arbiter with registered one-hot grant, one-cold copy and forced release after MAX_HOLD cycles.
// Optional SVA checks are compiled in when ARB_ASSERT_EN is defined.
module rr_onecold_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         gnt_n,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_d;
    logic [IW-1:0]  id_d;
    logic           busy_d, preempt_d;

    logic [IW-1:0]  owner_inc;
    logic [IW-1:0]  scan_start;
    logic [IW-1:0]  win;
    logic           found;
    logic           vol_rel, forced_rel;
    int unsigned    idx;

    // State register; gnt_id doubles as the owner index while in S_GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt     <= '0;
            gnt_n   <= '1;
            gnt_id  <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            gnt_n   <= ~gnt_d;
            gnt_id  <= id_d;
            busy    <= busy_d;
            preempt <= preempt_d;
        end
    end

    // Next-state, winner scan and output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gnt_d      = gnt;
        id_d       = gnt_id;
        busy_d     = busy;
        preempt_d  = 1'b0;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
        vol_rel    = 1'b0;
        forced_rel = 1'b0;

        owner_inc  = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
        // Scanning from owner+1 leaves the current owner lowest priority on release.
        scan_start = (state_q == S_GRANT) ? owner_inc : ptr_q;

        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(scan_start) + i) % N;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    gnt_d   = N'(1) << win;
                    id_d    = win;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                vol_rel    = !req[gnt_id];
                forced_rel = (hold_q == HW'(MAX_HOLD - 1));
                if (vol_rel || forced_rel) begin
                    ptr_d     = owner_inc;
                    // Preempt only when the owner still wanted the resource.
                    preempt_d = forced_rel && !vol_rel;
                    hold_d    = '0;
                    if (found) begin
                        gnt_d = N'(1) << win;
                        id_d  = win;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ARB_ASSERT_EN
    localparam int unsigned WB = N * MAX_HOLD;
    localparam int unsigned WW = $clog2(WB + 2);

    logic [WW-1:0] wait_cnt [N];

    // Cycles each requester has been waiting with its request continuously high.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (!rst_n || !req[i] || gnt[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != WW'(WB + 1)) begin
                wait_cnt[i] <= wait_cnt[i] + WW'(1);
            end
        end
    end

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("%0t: gnt not onehot0 (%b)", $time, gnt);
    a_onecold: assert property (@(posedge clk) disable iff (!rst_n) gnt_n == ~gnt)
        else $error("%0t: gnt_n %b != ~gnt %b", $time, gnt_n, gnt);
    a_busy_cold: assert property (@(posedge clk) disable iff (!rst_n) busy |-> $onehot(~gnt_n))
        else $error("%0t: busy with gnt_n=%b", $time, gnt_n);
    a_tenure: assert property (@(posedge clk) disable iff (!rst_n) busy |-> (hold_q < HW'(MAX_HOLD)))
        else $error("%0t: tenure exceeded MAX_HOLD", $time);

    for (genvar g = 0; g < N; g++) begin : g_starve
        a_starve: assert property (@(posedge clk) disable iff (!rst_n) wait_cnt[g] <= WW'(WB))
            else $error("%0t: requester %0d starved", $time, g);
    end
`endif

endmodule

// File: tb/tb_rr_onecold_arbiter.sv
// Directed table-driven bench for rr_onecold_arbiter (N=4, MAX_HOLD=8) plus multi-cycle sequences
// and a short random phase checked against a small reference model.
module tb_rr_onecold_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt, gnt_n;
    logic [1:0] gnt_id;
    logic       busy, preempt;

    int nvec = 0;
    int nerr = 0;

    rr_onecold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_n   (gnt_n),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g, logic [1:0] i,
                                logic b, logic p);
        vec_t v;
        v.rst_n = r; v.req = q; v.gnt = g; v.id = i; v.busy = b; v.pre = p;
        return v;
    endfunction

    // Drive on negedge, sample 1 time unit after the following posedge.
    task automatic apply(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst_n = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic ep);
        logic [3:0] egn;
        egn = ~eg;
        nvec++;
        if (gnt !== eg || gnt_n !== egn || gnt_id !== eid || busy !== eb || preempt !== ep) begin
            nerr++;
            $display("FAIL %s @%0t: got gnt=%b gnt_n=%b id=%0d busy=%b pre=%b, want gnt=%b gnt_n=%b id=%0d busy=%b pre=%b",
                     name, $time, gnt, gnt_n, gnt_id, busy, preempt, eg, egn, eid, eb, ep);
        end
    endtask

    // Reference model state for the random phase.
    int   m_owner, m_ptr, m_hold;
    logic m_busy, m_pre;

    function automatic int scan(logic [3:0] r, int s);
        for (int i = 0; i < N; i++) begin
            if (r[(s + i) % N]) return (s + i) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] q);
        int  w;
        bit  vol, frc;
        if (!r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
        end else if (!m_busy) begin
            m_pre = 0;
            w = scan(q, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_hold = 0;
            end
        end else begin
            vol = !q[m_owner];
            frc = (m_hold == MH - 1);
            m_pre = frc && !vol;
            if (vol || frc) begin
                m_ptr = (m_owner + 1) % N;
                w = scan(q, m_ptr);
                m_hold = 0;
                if (w >= 0) m_owner = w;
                else begin
                    m_busy = 0; m_owner = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    initial begin
        // Reset, idle grant, pointer advance, handover without bubble.
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 2'd2, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 4'b1000, 2'd3, 1, 0));
        tbl.push_back(mk(1, 4'b0001, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(1, 4'b1010, 4'b0010, 2'd1, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 4'b0001, 2'd0, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 4'b0010, 2'd1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst_n, tbl[i].req);
            check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].pre);
        end

        // All requesting: 8-cycle tenures rotating 0..3, preempt on each forced handover.
        apply(0, 4'b1111);
        check("rr_reset", 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            int o;
            logic [3:0] eg;
            o  = (k / MH) % N;
            eg = 4'b0001 << o;
            apply(1, 4'b1111);
            check($sformatf("rr_all k=%0d", k), eg, 2'(o), 1, (k >= MH) && (k % MH == 0));
        end

        // Sole requester: back-to-back tenures, preempt after cycles 8 and 16.
        apply(0, 4'b0000);
        check("solo_reset", 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            apply(1, 4'b0001);
            check($sformatf("solo k=%0d", k), 4'b0001, 2'd0, 1, (k == 8) || (k == 16));
        end

        // Reset mid-tenure drops the grant at that edge.
        apply(0, 4'b0000);
        for (int k = 0; k < 3; k++) apply(1, 4'b0100);
        check("mid_pre", 4'b0100, 2'd2, 1, 0);
        apply(0, 4'b0100);
        check("mid_reset", 4'b0000, 2'd0, 0, 0);
        apply(1, 4'b1000);
        check("mid_after", 4'b1000, 2'd3, 1, 0);

        // Random requests against the reference model.
        apply(0, 4'b0000);
        model_step(0, 4'b0000);
        check("rand_reset", 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            apply(1, r);
            model_step(1, r);
            $display("rand %0d: req=%b gnt=%b onehot(~gnt_n)=%0d", k, r, gnt, $onehot(~gnt_n));
            check($sformatf("rand k=%0d", k), m_busy ? (4'b0001 << m_owner) : 4'b0000,
                  2'(m_owner), m_busy, m_pre);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
